mvm_stream_top: RTL and testbench

MVM_STREAM_TOP -- requirements
Module: mvm_stream_top

---
 rtl/mvm_pkg.sv | 7 +
 rtl/mvm_mac_lane.sv | 44 ++++
 rtl/mvm_stream_top.sv | 86 ++++++++
 tb/tb_mvm_stream_top.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: FSM encoding and index-width helper shared by the matrix-vector stream unit
package mvm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, OUT = 2'd2} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mvm_mac_lane.sv
// mvm_mac_lane: one output lane, saturating MAC with sticky overflow and OUT_W clamp of the next accumulator value
module mvm_mac_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    w,
    input  logic signed [DW-1:0]    x,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
    logic signed [ACC_W-1:0] acc, acc_d;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   sum;
    logic sat_q, sat_d, ovf, clip_hi, clip_lo;
    always_comb begin
        prod    = w * x;
        sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
        ovf     = sum[ACC_W] != sum[ACC_W-1];
        acc_d   = !en ? acc : !ovf ? sum[ACC_W-1:0] : sum[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d   = sat_q | (en & ovf);
        clip_hi = acc_d > OUT_MAX;
        clip_lo = acc_d < OUT_MIN;
        res     = clip_hi ? OUT_MAX[OUT_W-1:0] : clip_lo ? OUT_MIN[OUT_W-1:0] : acc_d[OUT_W-1:0];
        sat     = sat_d | clip_hi | clip_lo;
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            sat_q <= 1'b0;
        end else begin
            acc   <= acc_d;
            sat_q <= sat_d;
        end
    end
endmodule

// File: rtl/mvm_stream_top.sv
// mvm_stream_top: streaming signed matrix-vector multiply with weight store, batch accumulation and valid/ready handshakes
module mvm_stream_top import mvm_pkg::*; #(
    parameter int DW    = 8,
    parameter int ROWS  = 16,
    parameter int COLS  = 4,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    localparam int AW   = idx_w(ROWS) + idx_w(COLS),
    localparam int KW   = idx_w(COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    input  logic [AW-1:0]              cfg_addr,
    input  logic signed [DW-1:0]       cfg_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic                       acc_mode,
    input  logic signed [COLS*DW-1:0]  x_vector_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ROWS*OUT_W-1:0] result_flat,
    output logic                       sat_flag,
    output logic [1:0]                 state
);
    state_t state_q, state_d;
    logic [KW-1:0] k_q;
    logic signed [DW-1:0] w_q [ROWS*COLS];
    logic signed [DW-1:0] x_q [COLS];
    logic last_q, mode_q, k_end, hs_in, hs_out;
    logic [ROWS*OUT_W-1:0] res_d;
    logic [ROWS-1:0] sat_v;
    always_comb begin
        in_ready = state_q == IDLE;
        hs_in    = in_valid & in_ready;
        hs_out   = out_valid & out_ready;
        k_end    = int'(k_q) == COLS - 1;
        state_d  = state_q == IDLE    ? (hs_in ? COMPUTE : IDLE) :
                   state_q == COMPUTE ? (!k_end ? COMPUTE : (!mode_q || last_q) ? OUT : IDLE) :
                   state_q == OUT     ? (hs_out ? IDLE : OUT) : IDLE;
    end
    assign state = state_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            last_q      <= 1'b0;
            mode_q      <= 1'b0;
            out_valid   <= 1'b0;
            result_flat <= '0;
            sat_flag    <= 1'b0;
            for (int i = 0; i < ROWS*COLS; i++) w_q[i] <= '0;
            for (int c = 0; c < COLS; c++) x_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= (state_q == COMPUTE && !k_end) ? k_q + 1'b1 : '0;
            out_valid <= state_d == OUT;
            if (cfg_valid && state_q == IDLE && int'(cfg_addr) < ROWS*COLS) w_q[cfg_addr] <= cfg_data;
            if (hs_in) begin
                last_q <= in_last;
                mode_q <= acc_mode;
                for (int c = 0; c < COLS; c++) x_q[c] <= x_vector_flat[c*DW +: DW];
            end
            // capture the lanes' post-final-add view so the result is registered the cycle OUT begins
            if (state_q == COMPUTE && state_d == OUT) begin
                result_flat <= res_d;
                sat_flag    <= |sat_v;
            end
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [AW-1:0] wi;
        assign wi = AW'(r*COLS) + AW'(k_q);
        mvm_mac_lane #(.DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .clk(clk),
            .rst(rst),
            .clr(hs_out),
            .en(state_q == COMPUTE),
            .w(w_q[wi]),
            .x(x_q[k_q]),
            .res(res_d[r*OUT_W +: OUT_W]),
            .sat(sat_v[r])
        );
    end
endmodule

// File: tb/tb_mvm_stream_top.sv
// tb_mvm_stream_top: scoreboard bench, reference model predicts each result when a vector is accepted
module tb_mvm_stream_top;
    localparam int DW = 8, ROWS = 16, COLS = 4, ACC_W = 24, OUT_W = 16, AW = 6;
    localparam longint AMAX = 64'sd8388607, AMIN = -64'sd8388608;
    localparam longint OMAX = 64'sd32767, OMIN = -64'sd32768;
    logic clk, rst, cfg_valid, in_valid, in_ready, in_last, acc_mode, out_valid, out_ready, sat_flag;
    logic [AW-1:0] cfg_addr;
    logic signed [DW-1:0] cfg_data;
    logic signed [COLS*DW-1:0] x_vector_flat;
    logic signed [ROWS*OUT_W-1:0] result_flat;
    logic [1:0] state;
    mvm_stream_top #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .acc_mode(acc_mode),
        .x_vector_flat(x_vector_flat), .out_valid(out_valid), .out_ready(out_ready),
        .result_flat(result_flat), .sat_flag(sat_flag), .state(state)
    );
    typedef struct packed {
        logic [ROWS*OUT_W-1:0] res;
        logic sat;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    longint wm [ROWS][COLS];
    longint am [ROWS];
    bit sm, lat_chk, ov_prev;
    int checks = 0, failures = 0, cyc = 0, t_hs = 0;
    logic [ROWS*OUT_W-1:0] cap;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic logic [COLS*DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) am[r] = 0;
        sm = 0;
    endtask
    task automatic model_accept(input logic [COLS*DW-1:0] xf, input bit last, input bit mode);
        longint v;
        exp_t e;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                am[r] += wm[r][c] * longint'($signed(xf[c*DW +: DW]));
                if (am[r] > AMAX) begin am[r] = AMAX; sm = 1; end
                if (am[r] < AMIN) begin am[r] = AMIN; sm = 1; end
            end
        if (!mode || last) begin
            for (int r = 0; r < ROWS; r++) begin
                v = am[r];
                if (v > OMAX) begin v = OMAX; sm = 1; end
                if (v < OMIN) begin v = OMIN; sm = 1; end
                e.res[r*OUT_W +: OUT_W] = v[OUT_W-1:0];
            end
            e.sat = sm;
            sb.push_back(e);
            model_clear();
        end
    endtask
    task automatic cfg_write(input int addr, input int data, input bit commit);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_addr = AW'(addr); cfg_data = 8'(data);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (commit) wm[addr/COLS][addr%COLS] = longint'($signed(8'(data)));
    endtask
    task automatic load_rows(input int a, input int b, input int c, input int d);
        int v[COLS];
        v = '{a, b, c, d};
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) cfg_write(r*COLS + k, v[k], 1'b1);
    endtask
    task automatic send_vec(input logic [COLS*DW-1:0] xf, input bit last, input bit mode, input bit model_it,
                            input bit cv = 1'b0, input int ca = 0, input int cd = 0);
        int n = 0;
        @(posedge clk); #1;
        x_vector_flat = xf; in_last = last; acc_mode = mode; in_valid = 1'b1;
        cfg_valid = cv; cfg_addr = AW'(ca); cfg_data = 8'(cd);
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        t_hs = cyc;
        if (cv) wm[ca/COLS][ca%COLS] = longint'(cd);
        if (model_it) model_accept(xf, last, mode);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0; cfg_valid = 1'b0;
    endtask
    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);
    endtask
    always @(negedge clk) begin
        if (out_valid && !ov_prev && lat_chk) begin
            check("latency", cyc - t_hs, COLS + 1);
            lat_chk = 0;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", 1, 0);
            else begin
                mon_e = sb.pop_front();
                for (int r = 0; r < ROWS; r++)
                    check($sformatf("lane%0d", r), longint'($signed(result_flat[r*OUT_W +: OUT_W])),
                          longint'($signed(mon_e.res[r*OUT_W +: OUT_W])));
                check("sat_flag", sat_flag, mon_e.sat);
            end
        end
        ov_prev = out_valid;
    end
    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; in_valid = 1'b0;
        in_last = 1'b0; acc_mode = 1'b0; x_vector_flat = '0; out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result_zero", result_flat == '0, 1);
        check("rst_sat", sat_flag, 0);
        load_rows(1, 2, 3, 4);
        lat_chk = 1;
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b0, 1'b1);
        wait_drain();
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b0, 1'b1, 1'b1, 5*COLS, 9);
        wait_drain();
        cfg_write(5*COLS, 1, 1'b1);
        load_rows(127, 127, 127, 127);
        send_vec(pk(-128, -128, -128, -128), 1'b0, 1'b0, 1'b1);
        wait_drain();
        load_rows(1, 2, 3, 4);
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b1, 1'b1);
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b1, 1'b1);
        send_vec(pk(1, 1, 1, 1), 1'b1, 1'b1, 1'b1);
        wait_drain();
        out_ready = 1'b0;
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("stall_out_valid_seen", out_valid, 1);
        cap = result_flat;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cfg_valid = 1'b1; cfg_addr = AW'(i*COLS); cfg_data = -8'sd7;
            @(negedge clk);
            check("stall_result_stable", result_flat == cap, 1);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_state", state, 2);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0; out_ready = 1'b1;
        wait_drain();
        send_vec(pk(1, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        wait_drain();
        load_rows(-128, -128, -128, -128);
        for (int i = 0; i < 130; i++) send_vec(pk(-128, -128, -128, -128), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 129; i++) send_vec(pk(127, 127, 127, 127), i == 128, 1'b1, 1'b1);
        wait_drain();
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < ROWS*COLS; a++) cfg_write(a, int'($urandom_range(0, 255)), 1'b1);
            send_vec(COLS*DW'($urandom), 1'b0, 1'b0, 1'b1);
            wait_drain();
        end
        load_rows(1, 2, 3, 4);
        send_vec(pk(1, 1, 1, 1), 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 0;
        model_clear();
        @(negedge clk);
        check("abort_state", state, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        repeat (8) @(negedge clk);
        send_vec(pk(5, 5, 5, 5), 1'b0, 1'b0, 1'b1);
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
